acorn128_host_if: RTL

- Upstream host-interface stage for acorn128_top.
- Loads key, IV, plaintext, associated data, length and mode through a 32-bit word-write port, then resets and launches the core.
- Holds the core's start level until it signals ready or a timeout fires.
- Captures ciphertext and tag, then streams them back as 8 words over a valid/ready read port.

---
 rtl/acorn128_pkg.sv | 29 ++
 rtl/acorn128_result_ser.sv | 65 ++++++
 rtl/acorn128_host_if.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/acorn128_pkg.sv
// acorn128_pkg
// Shared definitions for the acorn128 host-interface slice: the host word
// address map, the controller state encoding, the result length and a small
// address-validity helper.
package acorn128_pkg;

    localparam logic [4:0] ADDR_KEY0 = 5'd0;
    localparam logic [4:0] ADDR_IV0  = 5'd4;
    localparam logic [4:0] ADDR_PT0  = 5'd8;
    localparam logic [4:0] ADDR_AD0  = 5'd12;
    localparam logic [4:0] ADDR_LEN0 = 5'd16;
    localparam logic [4:0] ADDR_CTRL = 5'd18;

    localparam int RESULT_WORDS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CRST  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CAPT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Addresses above the control word do not map to any register.
    function automatic logic addr_is_valid(input logic [4:0] addr);
        return (addr <= ADDR_CTRL);
    endfunction

endpackage

// File: rtl/acorn128_result_ser.sv
// acorn128_result_ser
// Holds the captured ciphertext and tag (256 bits) and presents them to the
// host as eight 32-bit words over a valid/ready port, ct[31:0] first.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_load        capture i_ct/i_tag and start presenting word 0
//   i_ct, i_tag   128-bit ciphertext and tag from the core
//   i_rd_ready    host accepts the current word
//   o_rd_valid    current word valid
//   o_rd_data     current word
//   o_done        handshake of the last word is happening this cycle
module acorn128_result_ser
    import acorn128_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [127:0] i_ct,
    input  logic [127:0] i_tag,
    input  logic         i_rd_ready,
    output logic         o_rd_valid,
    output logic [31:0]  o_rd_data,
    output logic         o_done
);

    logic [255:0] r_words;
    logic [2:0]   r_idx;
    logic         r_valid;
    logic [31:0]  r_data;
    logic         w_hs;
    logic         w_last;

    assign w_hs   = r_valid && i_rd_ready;
    assign w_last = w_hs && (r_idx == 3'(RESULT_WORDS - 1));

    // Capture register shifts down one word per handshake, so the word being
    // presented is always the low 32 bits; rd data is held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_words <= 256'd0;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
            r_data  <= 32'd0;
        end else if (i_load) begin
            r_words <= {i_tag, i_ct};
            r_idx   <= 3'd0;
            r_valid <= 1'b1;
            r_data  <= i_ct[31:0];
        end else if (w_hs) begin
            r_words <= {32'd0, r_words[255:32]};
            r_idx   <= r_idx + 3'd1;
            if (w_last) begin
                r_valid <= 1'b0;
                r_data  <= 32'd0;
            end else begin
                r_data  <= r_words[63:32];
            end
        end
    end

    assign o_rd_valid = r_valid;
    assign o_rd_data  = r_data;
    assign o_done     = w_last;

endmodule

// File: rtl/acorn128_host_if.sv
// acorn128_host_if
// Host-side front end for acorn128_top. The host loads key/IV/plaintext/AD,
// length and mode as 32-bit words, pulses go, and this block resets the core,
// holds its start level until ready (or a timeout), captures ct/tag and
// streams them back as eight words.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   wr_valid_in/wr_ready_out      word-write handshake (ready only in IDLE)
//   wr_addr_in, wr_data_in        write address / data
//   go_in                         launch request (ignored unless IDLE)
//   busy_out, error_out           not-idle flag, sticky timeout/bad-address flag
//   rd_valid_out/rd_ready_in      result word handshake, rd_data_out data
//   core_*_out, core_*_in         connections to acorn128_top
// Build option: ACORN_ZEROIZE_EN clears key and plaintext after every capture
// and on timeout.
module acorn128_host_if
    import acorn128_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int TO_W           = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid_in,
    output logic         wr_ready_out,
    input  logic [4:0]   wr_addr_in,
    input  logic [31:0]  wr_data_in,
    input  logic         go_in,
    output logic         busy_out,
    output logic         error_out,
    output logic         rd_valid_out,
    input  logic         rd_ready_in,
    output logic [31:0]  rd_data_out,
    output logic         core_rst_out,
    output logic         core_start_out,
    output logic         core_encrypt_out,
    output logic [127:0] core_key_out,
    output logic [127:0] core_iv_out,
    output logic [127:0] core_pt_out,
    output logic [127:0] core_ad_out,
    output logic [63:0]  core_len_out,
    input  logic         core_ready_in,
    input  logic [127:0] core_ct_in,
    input  logic [127:0] core_tag_in
);

    state_t          r_state;
    state_t          w_next;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_core_rst;
    logic            r_start;
    logic            r_busy;
    logic            r_err;
    logic [127:0]    r_key, r_iv, r_pt, r_ad;
    logic [63:0]     r_len;
    logic            r_enc;
    logic            w_wr_acc;
    logic            w_go;
    logic            w_timeout;
    logic            w_done;

    assign w_wr_acc  = wr_valid_in && (r_state == ST_IDLE);
    assign w_go      = go_in && (r_state == ST_IDLE);
    // Ready has priority over the timeout in the same cycle.
    assign w_timeout = (r_state == ST_RUN) && !core_ready_in &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic for the launch/run/capture/drain sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_go) w_next = ST_CRST; else w_next = ST_IDLE;
            ST_CRST:  w_next = ST_RUN;
            ST_RUN: begin
                if (core_ready_in)  w_next = ST_CAPT;
                else if (w_timeout) w_next = ST_IDLE;
                else                w_next = ST_RUN;
            end
            ST_CAPT:  w_next = ST_DRAIN;
            ST_DRAIN: if (w_done) w_next = ST_IDLE; else w_next = ST_DRAIN;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register, run timer and registered core/status controls; the
    // controls are decoded from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_to_cnt   <= '0;
            r_core_rst <= 1'b1;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_core_rst <= (w_next == ST_CRST);
            r_start    <= (w_next == ST_RUN);
            r_busy     <= (w_next != ST_IDLE);
            if (r_state == ST_RUN) r_to_cnt <= r_to_cnt + TO_W'(1);
            else                   r_to_cnt <= '0;
            // A bad address written alongside go still flags this launch.
            if (w_timeout || (w_wr_acc && !addr_is_valid(wr_addr_in)))
                r_err <= 1'b1;
            else if (w_go)
                r_err <= 1'b0;
        end
    end

    // Operand/control registers: host word writes in IDLE, optional wipe of
    // the secret operands once a run is over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key <= 128'd0;
            r_iv  <= 128'd0;
            r_pt  <= 128'd0;
            r_ad  <= 128'd0;
            r_len <= 64'd0;
            r_enc <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                case (wr_addr_in[4:2])
                    3'd0: r_key[32*wr_addr_in[1:0] +: 32] <= wr_data_in;
                    3'd1: r_iv [32*wr_addr_in[1:0] +: 32] <= wr_data_in;
                    3'd2: r_pt [32*wr_addr_in[1:0] +: 32] <= wr_data_in;
                    3'd3: r_ad [32*wr_addr_in[1:0] +: 32] <= wr_data_in;
                    3'd4: begin
                        case (wr_addr_in[1:0])
                            2'd0:    r_len[31:0]  <= wr_data_in;
                            2'd1:    r_len[63:32] <= wr_data_in;
                            2'd2:    r_enc        <= wr_data_in[0];
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
`ifdef ACORN_ZEROIZE_EN
            if ((r_state == ST_CAPT) || w_timeout) begin
                r_key <= 128'd0;
                r_pt  <= 128'd0;
            end
`endif
        end
    end

    acorn128_result_ser u_ser (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == ST_CAPT),
        .i_ct       (core_ct_in),
        .i_tag      (core_tag_in),
        .i_rd_ready (rd_ready_in),
        .o_rd_valid (rd_valid_out),
        .o_rd_data  (rd_data_out),
        .o_done     (w_done)
    );

    assign wr_ready_out     = (r_state == ST_IDLE);
    assign busy_out         = r_busy;
    assign error_out        = r_err;
    assign core_rst_out     = r_core_rst;
    assign core_start_out   = r_start;
    assign core_encrypt_out = r_enc;
    assign core_key_out     = r_key;
    assign core_iv_out      = r_iv;
    assign core_pt_out      = r_pt;
    assign core_ad_out      = r_ad;
    assign core_len_out     = r_len;

endmodule
